i2c_master_core: RTL and testbench

// - Single-master I2C register-read engine for the MPU6050 sensor path (default slave 0x68).
// - One start pulse runs the sequence: write the register pointer, then stream read bytes until stop.
// - Sequence: START, addr+W, reg(data_in), Sr, addr+R, N bytes, NACK, STOP.
// - Presents each received byte on data_out with a 1-cycle strobe; idle flag gates new requests.

---
 rtl/i2c_master_core_if.sv | 25 ++
 rtl/i2c_master_core.sv | 194 +++++++++++++++++++
 tb/tb_i2c_master_core.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_core_if.sv
`default_nettype none
// ============================================================================
// i2c_master_core_if : request/response handshake of the I2C read engine
// Revision 1.0
// ============================================================================
interface i2c_master_core_if;
  logic [7:0] data_in;
  logic [6:0] slave_address;
  logic       start;
  logic       stop;
  logic [7:0] data_out;
  logic       avail_data_out;
  logic       avail_i2c_master;

  modport master (
    input  data_in, slave_address, start, stop,
    output data_out, avail_data_out, avail_i2c_master
  );

  modport slave (
    output data_in, slave_address, start, stop,
    input  data_out, avail_data_out, avail_i2c_master
  );
endinterface
`default_nettype wire

// File: rtl/i2c_master_core.sv
`default_nettype none
// ============================================================================
// i2c_master_core : I2C register-read engine (START, addr+W, reg, Sr, addr+R,
//                   byte stream with master ACK, NACK, STOP).
// Option macro I2C_MASTER_NACK_ABORT_EN: slave NACK on addr/reg aborts to STOP.
// Revision 1.0
// ============================================================================
module i2c_master_core #(
  parameter int DIV_FACTOR = 62
) (
  input  wire                      clk,
  input  wire                      reset,
  i2c_master_core_if.master        bus,
  inout  wire                      SDA_BUS,
  output logic                     SCL_BUS
);
  localparam int CW = $clog2(DIV_FACTOR);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_ADDR_W = 4'd2;
  localparam logic [3:0] S_ACK1   = 4'd3;
  localparam logic [3:0] S_REG    = 4'd4;
  localparam logic [3:0] S_ACK2   = 4'd5;
  localparam logic [3:0] S_RSTART = 4'd6;
  localparam logic [3:0] S_ADDR_R = 4'd7;
  localparam logic [3:0] S_ACK3   = 4'd8;
  localparam logic [3:0] S_READ   = 4'd9;
  localparam logic [3:0] S_MACK   = 4'd10;
  localparam logic [3:0] S_STOP   = 4'd11;

  logic [3:0]    r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_scl, r_sda_low, r_avail_data, r_stop_latch;
  logic [2:0]    r_bitcnt, w_bit_m1;
  logic [7:0]    r_shift, r_data_out, r_reg, w_tx_byte;
  logic [6:0]    r_addr;
  logic          w_tick, w_fall, w_last, w_abort, w_sda_in;

`ifdef I2C_MASTER_NACK_ABORT_EN
  logic r_nack;
  assign w_abort = r_nack;
`else
  assign w_abort = 1'b0;
`endif

  assign SDA_BUS  = r_sda_low ? 1'b0 : 1'bz;
  assign w_sda_in = SDA_BUS;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_tick    = (r_state != S_IDLE) && (r_cnt == CW'(DIV_FACTOR - 1));
    w_fall    = w_tick & r_scl;
    w_last    = (r_bitcnt == 3'd0);
    w_bit_m1  = r_bitcnt - 3'd1;
    w_tx_byte = (r_state == S_REG) ? r_reg : {r_addr, (r_state == S_ADDR_R)};
  end

  // Byte/ACK states advance on the tick that pulls SCL low.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start)          w_next = S_START;
      S_START:  if (w_tick)             w_next = S_ADDR_W;
      S_ADDR_W: if (w_fall && w_last)   w_next = S_ACK1;
      S_ACK1:   if (w_fall)             w_next = w_abort ? S_STOP : S_REG;
      S_REG:    if (w_fall && w_last)   w_next = S_ACK2;
      S_ACK2:   if (w_fall)             w_next = w_abort ? S_STOP : S_RSTART;
      S_RSTART: if (w_tick && r_scl && r_sda_low) w_next = S_ADDR_R;
      S_ADDR_R: if (w_fall && w_last)   w_next = S_ACK3;
      S_ACK3:   if (w_fall)             w_next = w_abort ? S_STOP : S_READ;
      S_READ:   if (w_fall && w_last)   w_next = S_MACK;
      S_MACK:   if (w_fall)             w_next = r_sda_low ? S_READ : S_STOP;
      S_STOP:   if (w_tick && r_scl)    w_next = S_IDLE;
      default:                          w_next = S_IDLE;
    endcase
  end

  always_comb begin
    SCL_BUS = r_scl;
  end
  assign bus.avail_i2c_master = (r_state == S_IDLE);
  assign bus.data_out         = r_data_out;
  assign bus.avail_data_out   = r_avail_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_scl        <= 1'b1;
      r_sda_low    <= 1'b0;
      r_bitcnt     <= 3'd0;
      r_shift      <= 8'h00;
      r_data_out   <= 8'h00;
      r_avail_data <= 1'b0;
      r_stop_latch <= 1'b0;
      r_addr       <= 7'h00;
      r_reg        <= 8'h00;
`ifdef I2C_MASTER_NACK_ABORT_EN
      r_nack       <= 1'b0;
`endif
    end else begin
      r_avail_data <= 1'b0;
      if (r_state == S_IDLE || w_tick) r_cnt <= '0;
      else                             r_cnt <= r_cnt + 1'b1;

      if (r_state == S_IDLE) begin
        if (bus.start) begin
          r_addr       <= bus.slave_address;
          r_reg        <= bus.data_in;
          r_stop_latch <= 1'b0;
          r_sda_low    <= 1'b1;
        end
      end else if (bus.stop) begin
        r_stop_latch <= 1'b1;
      end

      if (w_tick) begin
        case (r_state)
          S_START: begin
            r_scl     <= 1'b0;
            r_bitcnt  <= 3'd7;
            r_sda_low <= ~r_addr[6];
          end
          // Repeated start takes three half-periods: SCL up, SDA down, SCL down.
          S_RSTART: begin
            if (!r_scl)          r_scl     <= 1'b1;
            else if (!r_sda_low) r_sda_low <= 1'b1;
            else begin
              r_scl     <= 1'b0;
              r_bitcnt  <= 3'd7;
              r_sda_low <= ~r_addr[6];
            end
          end
          S_STOP: begin
            if (!r_scl) r_scl     <= 1'b1;
            else        r_sda_low <= 1'b0;
          end
          default: begin
            if (!r_scl) begin
              r_scl <= 1'b1;
              if (r_state == S_READ) r_shift <= {r_shift[6:0], w_sda_in};
`ifdef I2C_MASTER_NACK_ABORT_EN
              r_nack <= w_sda_in;
`endif
            end else begin
              r_scl <= 1'b0;
              case (r_state)
                S_ADDR_W, S_REG, S_ADDR_R: begin
                  if (w_last) r_sda_low <= 1'b0;
                  else begin
                    r_bitcnt  <= w_bit_m1;
                    r_sda_low <= ~w_tx_byte[w_bit_m1];
                  end
                end
                S_ACK1: begin
                  if (w_abort) r_sda_low <= 1'b1;
                  else begin
                    r_bitcnt  <= 3'd7;
                    r_sda_low <= ~r_reg[7];
                  end
                end
                S_ACK2: r_sda_low <= w_abort;
                S_ACK3: begin
                  r_sda_low <= w_abort;
                  r_bitcnt  <= 3'd7;
                end
                S_READ: begin
                  if (w_last) begin
                    r_data_out   <= r_shift;
                    r_avail_data <= 1'b1;
                    r_sda_low    <= ~r_stop_latch;
                  end else begin
                    r_bitcnt <= w_bit_m1;
                  end
                end
                // ACK was driven -> release for next byte; NACK -> hold low for STOP.
                S_MACK: begin
                  r_sda_low <= ~r_sda_low;
                  r_bitcnt  <= 3'd7;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_i2c_master_core.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for i2c_master_core: directed register-read transactions against a
// behavioural MPU6050-style slave that logs every SCL-high SDA bit.
module tb_i2c_master_core;
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  i2c_master_core_if ifc();
  wire  sda;
  logic scl_bus;
  logic s_low;
  logic tb_mute;
  pullup (sda);
  assign sda = (s_low === 1'b1 && tb_mute !== 1'b1) ? 1'b0 : 1'bz;

  i2c_master_core #(.DIV_FACTOR(62)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .bus     (ifc.master),
    .SDA_BUS (sda),
    .SCL_BUS (scl_bus)
  );

  int n_vec, n_bad;
  logic       s_ack_en;
  logic [7:0] s_rd_byte;
  logic       p_scl, p_sda, s_done;
  int         s_cnt, s_phase;
  logic       mon_bits [0:127];
  longint     mon_t    [0:127];
  int         start_pos[0:15];
  int         mon_n, n_start, stop_cnt, strobe_cnt;
  logic [7:0] last_data;

  function automatic logic slave_bit(input int ph, input int p, input logic done);
    int q;
    slave_bit = 1'b0;
    if (ph == 1) slave_bit = ((p % 9) == 8) && s_ack_en;
    else if (ph == 2) begin
      if (p == 8) slave_bit = s_ack_en;
      else if (p >= 9 && !done) begin
        q = (p - 9) % 9;
        if (q < 8) slave_bit = ~s_rd_byte[7 - q];
      end
    end
  endfunction

  always @(negedge clk) begin
    p_scl <= scl_bus;
    p_sda <= sda;
    if (rst_n !== 1'b1) begin
      s_low <= 1'b0; s_phase <= 0; s_done <= 1'b0; s_cnt <= 0;
    end else if (scl_bus === 1'b1 && p_scl === 1'b0) begin
      if (mon_n < 128) begin
        mon_bits[mon_n] <= sda;
        mon_t[mon_n]    <= $time;
      end
      mon_n <= mon_n + 1;
      if (s_phase == 2 && s_cnt >= 17 && ((s_cnt - 9) % 9) == 8 && sda === 1'b1) s_done <= 1'b1;
      s_cnt <= s_cnt + 1;
    end else if (scl_bus === 1'b0 && p_scl === 1'b1) begin
      s_low <= slave_bit(s_phase, s_cnt, s_done);
    end else if (scl_bus === 1'b1 && p_scl === 1'b1 && p_sda === 1'b1 && sda === 1'b0) begin
      if (n_start < 16) start_pos[n_start] <= mon_n;
      n_start <= n_start + 1;
      s_phase <= s_phase + 1;
      s_cnt   <= 0;
      s_done  <= 1'b0;
    end else if (scl_bus === 1'b1 && p_scl === 1'b1 && p_sda === 1'b0 && sda === 1'b1) begin
      stop_cnt <= stop_cnt + 1;
      s_phase  <= 0;
    end
  end

  always @(negedge clk) begin
    if (ifc.avail_data_out === 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      last_data  <= ifc.data_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input int idx);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) v = {v[6:0], mon_bits[idx + i]};
    return v;
  endfunction

  task automatic do_start(input logic [6:0] a, input logic [7:0] d);
    ifc.slave_address = a;
    ifc.data_in       = d;
    ifc.start         = 1'b1;
    @(negedge clk);
    ifc.start         = 1'b0;
  endtask

  task automatic pulse_stop();
    ifc.stop = 1'b1;
    @(negedge clk);
    ifc.stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (ifc.avail_i2c_master !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, (t < 20000), 1);
    repeat (3) @(negedge clk);
  endtask

  int b, bs, bst, bsb, t, scl_low;

  initial begin
    tb_mute = 1'b1;
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.data_in = 8'h00; ifc.slave_address = 7'h00;
    s_ack_en = 1'b1; s_rd_byte = 8'hF0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_scl", scl_bus, 1);
    chk("rst_sda", sda, 1);
    chk("rst_idle", ifc.avail_i2c_master, 1);
    chk("rst_data", ifc.data_out, 8'h00);
    chk("rst_strobe", ifc.avail_data_out, 0);
    rst_n = 1'b1; tb_mute = 1'b0;
    repeat (5) @(negedge clk);

    // A: normal read of two 0xF0 bytes, stop during the second byte
    b = mon_n; bs = n_start; bst = stop_cnt; bsb = strobe_cnt;
    do_start(7'h68, 8'h31);
    chk("A_busy", ifc.avail_i2c_master, 0);
    repeat (200) @(negedge clk);
    do_start(7'h11, 8'hAA);
    t = 0;
    while (strobe_cnt == bsb && t < 20000) begin @(negedge clk); t++; end
    chk("A_strobe1_wait", (t < 20000), 1);
    chk("A_byte1_out", ifc.data_out, 8'hF0);
    repeat (500) @(negedge clk);
    pulse_stop();
    wait_idle("A_idle_wait");
    chk("A_addr_w", get_byte(b), 8'hD0);
    chk("A_ack1", mon_bits[b + 8], 0);
    chk("A_reg", get_byte(b + 9), 8'h31);
    chk("A_ack2", mon_bits[b + 17], 0);
    chk("A_sr_scl_high", mon_bits[b + 18], 1);
    chk("A_sr_pos", start_pos[bs + 1], b + 19);
    chk("A_addr_r", get_byte(b + 19), 8'hD1);
    chk("A_ack3", mon_bits[b + 27], 0);
    chk("A_rd1", get_byte(b + 28), 8'hF0);
    chk("A_mack", mon_bits[b + 36], 0);
    chk("A_rd2", get_byte(b + 37), 8'hF0);
    chk("A_nack", mon_bits[b + 45], 1);
    chk("A_stop_rise", mon_bits[b + 46], 0);
    chk("A_nbits", mon_n - b, 47);
    chk("A_starts", n_start - bs, 2);
    chk("A_stops", stop_cnt - bst, 1);
    chk("A_strobes", strobe_cnt - bsb, 2);
    chk("A_data_out", last_data, 8'hF0);
    chk("A_scl_period", 32'(mon_t[b + 1] - mon_t[b]), 2480);
    chk("A_end_scl", scl_bus, 1);
    chk("A_end_sda", sda, 1);

    // B: slave never ACKs; stop requested right after start
    s_ack_en = 1'b0; s_rd_byte = 8'h5A;
    b = mon_n; bs = n_start; bst = stop_cnt; bsb = strobe_cnt;
    do_start(7'h68, 8'h75);
    pulse_stop();
    wait_idle("B_idle_wait");
    chk("B_addr_w", get_byte(b), 8'hD0);
    chk("B_ack1_nack", mon_bits[b + 8], 1);
    chk("B_stops", stop_cnt - bst, 1);
`ifdef I2C_MASTER_NACK_ABORT_EN
    chk("B_stop_rise", mon_bits[b + 9], 0);
    chk("B_nbits", mon_n - b, 10);
    chk("B_starts", n_start - bs, 1);
    chk("B_strobes", strobe_cnt - bsb, 0);
`else
    chk("B_reg", get_byte(b + 9), 8'h75);
    chk("B_ack2_nack", mon_bits[b + 17], 1);
    chk("B_addr_r", get_byte(b + 19), 8'hD1);
    chk("B_rd1", get_byte(b + 28), 8'h5A);
    chk("B_nack", mon_bits[b + 36], 1);
    chk("B_nbits", mon_n - b, 38);
    chk("B_starts", n_start - bs, 2);
    chk("B_strobes", strobe_cnt - bsb, 1);
    chk("B_data_out", last_data, 8'h5A);
`endif

    // C: reset in the middle of a READ byte
    s_ack_en = 1'b1; s_rd_byte = 8'hA5;
    b = mon_n; bsb = strobe_cnt;
    do_start(7'h68, 8'h3B);
    t = 0;
    while (mon_n < b + 31 && t < 20000) begin @(negedge clk); t++; end
    chk("C_read_wait", (t < 20000), 1);
    tb_mute = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("C_rst_scl", scl_bus, 1);
    chk("C_rst_sda", sda, 1);
    chk("C_rst_idle", ifc.avail_i2c_master, 1);
    chk("C_rst_data", ifc.data_out, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    scl_low = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (scl_bus !== 1'b1) scl_low++;
    end
    chk("C_no_scl", scl_low, 0);
    chk("C_no_strobe", strobe_cnt - bsb, 0);
    chk("C_still_idle", ifc.avail_i2c_master, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
